// File: rtl/wb_pkg.sv
// Shared Wishbone types and widths for the two-master arbiter.
package wb_pkg;

    localparam int WB_AW   = 30;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = WB_DW / 8;

    // Encoding doubles as the one-hot grant vector {B, A}.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_A = 2'b01,
        ARB_GNT_B = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic               cyc;
        logic               stb;
        logic               we;
        logic [WB_AW-1:0]   addr;
        logic [WB_DW-1:0]   data;
        logic [WB_SELW-1:0] sel;
    } wb_req_t;

    typedef struct packed {
        logic             stall;
        logic             ack;
        logic             err;
        logic [WB_DW-1:0] data;
    } wb_rsp_t;

    // Response seen by a master that does not own the bus.
    function automatic wb_rsp_t parked_rsp(input logic cyc);
        wb_rsp_t r;
        r       = '0;
        r.stall = cyc;
        return r;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-hang watchdog: counts idle granted cycles and pulses expire at LIMIT.
module wb_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || clear) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = active && (count == CW'(LIMIT));

endmodule

// File: rtl/wb_arbiter_2m.sv
// Round-robin, per-cycle-transaction arbiter sharing one Wishbone slave between masters A and B.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------|------------------------------------------------------
// ARB_IDLE  | no owner; slave request lines forced low
// ARB_GNT_A | master A owns the slave until its cyc falls
// ARB_GNT_B | master B owns the slave until its cyc falls
// last = 1 means B was served most recently, so A wins the next tie.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int AW             = WB_AW,
    parameter int DW             = WB_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_s_cyc,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data,
    output logic [DW/8-1:0] o_s_sel,
    input  logic            i_s_stall,
    input  logic            i_s_ack,
    input  logic            i_s_err,
    input  logic [DW-1:0]   i_s_data,
    output logic [1:0]      o_grant
);
    arb_state_t state, state_next;
    logic       last, last_next;
    logic       expire;
    wb_req_t    req_a, req_b, req_s;
    wb_rsp_t    rsp_s, rsp_a, rsp_b;

    assign req_a = '{cyc: i_a_cyc, stb: i_a_stb, we: i_a_we,
                     addr: i_a_addr, data: i_a_data, sel: i_a_sel};
    assign req_b = '{cyc: i_b_cyc, stb: i_b_stb, we: i_b_we,
                     addr: i_b_addr, data: i_b_data, sel: i_b_sel};
    assign rsp_s = '{stall: i_s_stall, ack: i_s_ack, err: i_s_err, data: i_s_data};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            ARB_IDLE: begin
                if (i_a_cyc && (!i_b_cyc || last)) state_next = ARB_GNT_A;
                else if (i_b_cyc)                  state_next = ARB_GNT_B;
            end
            ARB_GNT_A: begin
                if (expire || !i_a_cyc) begin
                    last_next  = 1'b0;
                    state_next = (i_b_cyc && !expire) ? ARB_GNT_B : ARB_IDLE;
                end
            end
            ARB_GNT_B: begin
                if (expire || !i_b_cyc) begin
                    last_next  = 1'b1;
                    state_next = (i_a_cyc && !expire) ? ARB_GNT_A : ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // On watchdog expiry the slave cycle is dropped and the owner gets a synthetic err.
    always_comb begin
        req_s = '0;
        rsp_a = parked_rsp(i_a_cyc);
        rsp_b = parked_rsp(i_b_cyc);
        case (state)
            ARB_GNT_A: begin
                if (expire) begin
                    rsp_a.err = 1'b1;
                end else begin
                    req_s = req_a;
                    rsp_a = rsp_s;
                end
            end
            ARB_GNT_B: begin
                if (expire) begin
                    rsp_b.err = 1'b1;
                end else begin
                    req_s = req_b;
                    rsp_b = rsp_s;
                end
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_clear;

    assign wd_clear = (req_s.stb && !i_s_stall) || i_s_ack || i_s_err || (state_next != state);

    wb_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .active (state != ARB_IDLE),
        .clear  (wd_clear),
        .expire (expire)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    assign {o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel} = req_s;
    assign {o_a_stall, o_a_ack, o_a_err, o_a_data}                = rsp_a;
    assign {o_b_stall, o_b_ack, o_b_err, o_b_data}                = rsp_b;
    assign o_grant = state;

endmodule
